clock_div_bank: RTL and testbench

Parametrised bank of independent clock dividers, generalising the fixed three-output divider into NUM_CH channels.
- Each channel has a runtime-programmable divisor, a per-channel enable and a glitch-free divisor update at terminal count.
- An optional single-cycle tick output is available per channel.
- It sits between the board clock and slow logic such as counters and display multiplexers, producing 50%-duty enable/clock signals.

---
 rtl/clkdiv_pkg.sv | 15 +
 rtl/clkdiv_ch.sv | 74 +++++++
 rtl/clock_div_bank.sv | 59 +++++
 tb/tb_clock_div_bank.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and reset-divisor helper for the clock divider bank.
package clkdiv_pkg;

    localparam int MAX_CH = 8;
    localparam int CNT_W_DEF = 27;
    localparam longint unsigned DEF_DIV_DEF = 100000000;

    // Channel i starts at base >> i, never below one cycle per half-period.
    function automatic longint unsigned def_div(input longint unsigned base, input int i);
        longint unsigned d;
        d = base >> i;
        return (d == 0) ? 64'd1 : d;
    endfunction

endpackage

// File: rtl/clkdiv_ch.sv
// One divider channel: counter, active/shadow divisor, pending flag and 50% output.
// The registered tick output exists only when CLKDIV_TICK_EN is defined.
module clkdiv_ch
    import clkdiv_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_DIV = {{(CNT_W-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wdiv,
    output logic             pend,
    output logic             clko,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shadow;
    logic             tc;

    assign tc = en && (cnt == div - ONE);

    // Divisor swaps happen only at a terminal count or while held, so cnt is
    // always zero when div changes and no half-period is ever cut short.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            div    <= RST_DIV;
            shadow <= RST_DIV;
            pend   <= 1'b0;
            clko   <= 1'b0;
        end else begin
            if (!en) begin
                cnt  <= '0;
                clko <= 1'b0;
                if (pend) begin
                    div  <= shadow;
                    pend <= 1'b0;
                end
            end else if (tc) begin
                cnt  <= '0;
                clko <= ~clko;
                if (pend) begin
                    div  <= shadow;
                    pend <= 1'b0;
                end
            end else begin
                cnt <= cnt + ONE;
            end
            if (wr) begin
                shadow <= wdiv;
                pend   <= 1'b1;
            end
        end
    end

`ifdef CLKDIV_TICK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= tc;
        end
    end
`else
    assign tick = 1'b0;
`endif

endmodule

// File: rtl/clock_div_bank.sv
// Bank of NUM_CH independent programmable clock dividers with stalled divisor writes.
// Define CLKDIV_TICK_EN to get a one-cycle tick per clko toggle; otherwise tick is 0.
module clock_div_bank
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W = CNT_W_DEF,
    parameter longint unsigned DEF_DIV = DEF_DIV_DEF,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clko,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] wr;
    logic [CNT_W-1:0]  wdiv;

    assign wdiv = (cfg_div == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : cfg_div;

    // Out-of-range channels stay ready so their writes drain and are dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [CH_W-1:0]  SEL = CH_W'(g);
        localparam logic [CNT_W-1:0] RDIV = CNT_W'(def_div(DEF_DIV, g));

        assign wr[g] = cfg_valid & cfg_ready & (cfg_ch == SEL);

        clkdiv_ch #(
            .CNT_W  (CNT_W),
            .RST_DIV(RDIV)
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .en  (en[g]),
            .wr  (wr[g]),
            .wdiv(wdiv),
            .pend(pend[g]),
            .clko(clko[g]),
            .tick(tick[g])
        );
    end

endmodule

// File: tb/tb_clock_div_bank.sv
// Directed self-checking bench for clock_div_bank (NUM_CH=3, CNT_W=8, DEF_DIV=8).
// Tick expectations follow whether CLKDIV_TICK_EN is defined for the build.
module tb_clock_div_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [2:0] clko;
    logic [2:0] tick;

    int n_checks = 0;
    int n_errors = 0;

`ifdef CLKDIV_TICK_EN
    localparam bit TICK_ON = 1'b1;
`else
    localparam bit TICK_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    clock_div_bank #(
        .NUM_CH (3),
        .CNT_W  (8),
        .DEF_DIV(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .clko     (clko),
        .tick     (tick)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [2:0] e, input logic v,
                                 input logic [1:0] ch, input logic [7:0] d);
        rst       = r;
        en        = e;
        cfg_valid = v;
        cfg_ch    = ch;
        cfg_div   = d;
        #1;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    // Default divisors 8/4/2: after enabled edge k, clko = (k/D) odd, tick = (k%D == 0).
    function automatic logic [2:0] ref_clko(input int k);
        logic [2:0] r;
        r[0] = ((k / 8) % 2) != 0;
        r[1] = ((k / 4) % 2) != 0;
        r[2] = ((k / 2) % 2) != 0;
        return r;
    endfunction

    function automatic logic [2:0] ref_tick(input int k);
        logic [2:0] r;
        r[0] = (k % 8) == 0;
        r[1] = (k % 4) == 0;
        r[2] = (k % 2) == 0;
        return TICK_ON ? r : 3'b000;
    endfunction

    task automatic doReset();
        applyStimulus(1'b1, 3'b000, 1'b0, 2'd0, 8'd0);
        nextEdge();
        checkOutput("rst_clko", clko, 3'b000);
        checkOutput("rst_tick", tick, 3'b000);
        checkOutput("rst_ready", cfg_ready, 1'b1);
        nextEdge();
        applyStimulus(1'b0, 3'b111, 1'b0, 2'd0, 8'd0);
    endtask

    task automatic runDefault(input string name, input int n);
        for (int j = 1; j <= n; j++) begin
            nextEdge();
            checkOutput($sformatf("%s_clko_e%0d", name, j), clko, ref_clko(j));
            checkOutput($sformatf("%s_tick_e%0d", name, j), tick, ref_tick(j));
        end
    endtask

    initial begin
        // Free-running default divisors
        doReset();
        runDefault("s1", 32);

        // Divisor write on ch0 mid half-period, second write held off
        doReset();
        for (int k = 1; k <= 3; k++) nextEdge();
        applyStimulus(1'b0, 3'b111, 1'b1, 2'd0, 8'd3);
        checkOutput("s2_ready_pre", cfg_ready, 1'b1);
        for (int k = 4; k <= 20; k++) begin
            nextEdge();
            checkOutput($sformatf("s2_clko0_e%0d", k), clko[0],
                        (k < 8) ? 1'b0 : ((((k - 8) / 3) % 2) == 0));
            if (k == 4) applyStimulus(1'b0, 3'b111, 1'b1, 2'd0, 8'd5);
            if (k <= 7) checkOutput($sformatf("s2_ready_held_e%0d", k), cfg_ready, 1'b0);
            if (k == 7) applyStimulus(1'b0, 3'b111, 1'b0, 2'd0, 8'd5);
            if (k == 8) checkOutput("s2_ready_after_tc", cfg_ready, 1'b1);
        end

        // Zero divisor on ch1 behaves as one
        applyStimulus(1'b0, 3'b111, 1'b1, 2'd1, 8'd0);
        checkOutput("s3_ready_pre", cfg_ready, 1'b1);
        for (int k = 21; k <= 30; k++) begin
            nextEdge();
            if (k == 21) begin
                applyStimulus(1'b0, 3'b111, 1'b0, 2'd1, 8'd0);
                checkOutput("s3_ready_pend", cfg_ready, 1'b0);
            end
            checkOutput($sformatf("s3_clko1_e%0d", k), clko[1],
                        (k < 24) ? (((k / 4) % 2) != 0) : (((k - 24) % 2) != 0));
            checkOutput($sformatf("s3_tick1_e%0d", k), tick[1],
                        TICK_ON && ((k >= 24) || ((k % 4) == 0)));
            if (k == 24) checkOutput("s3_ready_after_tc", cfg_ready, 1'b1);
        end

        // Pending write on ch2 applied while held, then re-enable
        applyStimulus(1'b0, 3'b111, 1'b1, 2'd2, 8'd5);
        checkOutput("s4_ready_pre", cfg_ready, 1'b1);
        nextEdge();
        applyStimulus(1'b0, 3'b011, 1'b0, 2'd2, 8'd5);
        checkOutput("s4_ready_pend", cfg_ready, 1'b0);
        checkOutput("s4_clko2_high", clko[2], 1'b1);
        for (int k = 32; k <= 34; k++) begin
            nextEdge();
            checkOutput($sformatf("s4_clko2_held_e%0d", k), clko[2], 1'b0);
            checkOutput($sformatf("s4_tick2_held_e%0d", k), tick[2], 1'b0);
            if (k == 32) checkOutput("s4_ready_cleared", cfg_ready, 1'b1);
        end
        applyStimulus(1'b0, 3'b111, 1'b0, 2'd2, 8'd5);
        for (int j = 1; j <= 10; j++) begin
            nextEdge();
            checkOutput($sformatf("s4_clko2_re_e%0d", j), clko[2], ((j / 5) % 2) != 0);
            checkOutput($sformatf("s4_tick2_re_e%0d", j), tick[2], TICK_ON && ((j % 5) == 0));
        end

        // Reset mid-count discards a pending ch0 write
        applyStimulus(1'b0, 3'b111, 1'b1, 2'd0, 8'd7);
        checkOutput("s5_ready_pre", cfg_ready, 1'b1);
        nextEdge();
        applyStimulus(1'b1, 3'b111, 1'b0, 2'd0, 8'd7);
        checkOutput("s5_ready_pend", cfg_ready, 1'b0);
        nextEdge();
        checkOutput("s5_rst_clko", clko, 3'b000);
        checkOutput("s5_rst_tick", tick, 3'b000);
        checkOutput("s5_rst_ready0", cfg_ready, 1'b1);
        for (int ch = 1; ch <= 3; ch++) begin
            applyStimulus(1'b1, 3'b111, 1'b0, 2'(ch), 8'd0);
            checkOutput($sformatf("s5_rst_ready%0d", ch), cfg_ready, 1'b1);
        end
        applyStimulus(1'b0, 3'b111, 1'b1, 2'd3, 8'd1);
        checkOutput("s5_ready_oor", cfg_ready, 1'b1);
        nextEdge();
        checkOutput("s5_clko_e1", clko, ref_clko(1));
        applyStimulus(1'b0, 3'b111, 1'b0, 2'd0, 8'd0);
        for (int j = 2; j <= 24; j++) begin
            nextEdge();
            checkOutput($sformatf("s5_clko_e%0d", j), clko, ref_clko(j));
            checkOutput($sformatf("s5_tick_e%0d", j), tick, ref_tick(j));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
